// File: rtl/bitwise_logic_pipe_if.sv
// Operand/result stream bundle for bitwise_logic_pipe: valid/ready beat input, valid/ready result output.
// The slave modport is the unit's view and the master modport is the source/sink view.
interface bitwise_logic_pipe_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             acc;
  logic             last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             zero;
  logic             parity;
  logic [CNT_W-1:0] beats;

  modport slave (
    input  in_valid, op, A, B, acc, last, out_ready,
    output in_ready, out_valid, S, zero, parity, beats
  );

  modport master (
    output in_valid, op, A, B, acc, last, out_ready,
    input  in_ready, out_valid, S, zero, parity, beats
  );
endinterface

// File: rtl/bitwise_logic_pipe.sv
// Registered 8-op bitwise unit with burst fold; 1-cycle latency from the accepted (producing) beat.
// in_ready = !out_valid || out_ready; S/zero/parity/beats hold while a result waits on out_ready.
module bitwise_logic_pipe #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input logic                clk,
  input logic                rst_n,
  bitwise_logic_pipe_if.slave io
);

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_XNOR = 3'b100;
  localparam logic [2:0] OP_NAND = 3'b101;
  localparam logic [2:0] OP_ANDN = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  function automatic logic [WIDTH-1:0] logic_op(
    input logic [2:0]       sel,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y
  );
    logic [WIDTH-1:0] r;
    unique case (sel)
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_XOR:  r = x ^ y;
      OP_NOR:  r = ~(x | y);
      OP_XNOR: r = ~(x ^ y);
      OP_NAND: r = ~(x & y);
      OP_ANDN: r = x & ~y;
      OP_PASS: r = x;
    endcase
    return r;
  endfunction

  state_t           state;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] c_cnt;

  logic             out_valid_q;
  logic [WIDTH-1:0] s_q;
  logic             zero_q;
  logic             parity_q;
  logic [CNT_W-1:0] beats_q;

  logic             accept;
  logic [WIDTH-1:0] fold_ab;
  logic [WIDTH-1:0] fold_ra;
  logic [CNT_W-1:0] c_inc;

  logic             produce;
  logic [WIDTH-1:0] res;
  logic [CNT_W-1:0] res_beats;

  assign io.in_ready  = !out_valid_q || io.out_ready;
  assign io.out_valid = out_valid_q;
  assign io.S         = s_q;
  assign io.zero      = zero_q;
  assign io.parity    = parity_q;
  assign io.beats     = beats_q;

  assign accept  = io.in_valid && io.in_ready;
  assign fold_ab = logic_op(io.op, io.A, io.B);
  assign fold_ra = logic_op(io.op, r_acc, io.A);
  // Beat counter sticks at all-ones instead of wrapping.
  assign c_inc   = (&c_cnt) ? c_cnt : c_cnt + ONE;

  always_comb begin
    produce   = 1'b0;
    res       = fold_ab;
    res_beats = ONE;
    if (accept) begin
      unique case (state)
        IDLE: begin
          if (!io.acc) begin
            produce = 1'b1;
            res     = fold_ab;
          end else if (io.last) begin
            // Single-beat burst: the fold of one value is the value itself.
            produce = 1'b1;
            res     = io.A;
          end
        end
        ACCUM: begin
          if (io.last) begin
            produce   = 1'b1;
            res       = fold_ra;
            res_beats = c_inc;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      r_acc       <= '0;
      c_cnt       <= '0;
      out_valid_q <= 1'b0;
      s_q         <= '0;
      zero_q      <= 1'b0;
      parity_q    <= 1'b0;
      beats_q     <= '0;
    end else begin
      if (produce) begin
        out_valid_q <= 1'b1;
        s_q         <= res;
        zero_q      <= (res == '0);
        parity_q    <= ^res;
        beats_q     <= res_beats;
      end else if (io.out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (accept) begin
        unique case (state)
          IDLE: begin
            if (io.acc && !io.last) begin
              r_acc <= io.A;
              c_cnt <= ONE;
              state <= ACCUM;
            end
          end
          ACCUM: begin
            // Inside a burst the acc bit is ignored; every beat folds.
            if (io.last) begin
              r_acc <= '0;
              c_cnt <= '0;
              state <= IDLE;
            end else begin
              r_acc <= fold_ra;
              c_cnt <= c_inc;
            end
          end
        endcase
      end
    end
  end

  a_hold_stable: assert property (
    @(posedge clk) disable iff (!rst_n)
    (out_valid_q && !io.out_ready) |=> (out_valid_q && $stable(s_q) && $stable(beats_q))
  );

endmodule
